// File: rtl/tdp_ram_pkg.sv
// Shared constants, FSM encoding and byte-lane mask helper for the tdp_ram_be
// true-dual-port RAM.
package tdp_ram_pkg;

    localparam int unsigned RM_READ_FIRST  = 0;
    localparam int unsigned RM_WRITE_FIRST = 1;

    localparam int unsigned PRIO_A = 0;
    localparam int unsigned PRIO_B = 1;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    // Upper bounds the mask helper can serve; callers truncate to their width.
    localparam int unsigned MAX_NB = 128;
    localparam int unsigned MAX_DW = 1024;

    // Expand one enable bit per lane into a bit mask covering that lane.
    function automatic logic [MAX_DW-1:0] lane_mask(input logic [MAX_NB-1:0] we,
                                                     input int unsigned       byte_w,
                                                     input int unsigned       nb);
        logic [MAX_DW-1:0] m;
        m = '0;
        for (int unsigned b = 0; b < MAX_DW; b++) begin
            if (b < nb * byte_w) begin
                m[10'(b)] = we[7'(b / byte_w)];
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/tdp_ram_init_ctrl.sv
// INIT/RUN sequencer: sweeps zeros through the array after reset by taking
// over port A, then hands port A back to the user and raises init_done.
module tdp_ram_init_ctrl
    import tdp_ram_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 6,
    parameter int unsigned NB         = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en_a,
    input  logic [NB-1:0]         we_a,
    input  logic [ADDR_WIDTH-1:0] addr_a,
    input  logic [DATA_WIDTH-1:0] din_a,
    output logic                  init_done,
    output logic                  run_c,
    output logic                  pa_en_c,
    output logic [NB-1:0]         pa_we_c,
    output logic [ADDR_WIDTH-1:0] pa_addr_c,
    output logic [DATA_WIDTH-1:0] pa_din_c
);

    state_e                  state;
    state_e                  next_state;
    logic [ADDR_WIDTH-1:0]   cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_INIT;
        end else begin
            state <= next_state;
        end
    end

    // The sweep ends on the cycle that clears the top address.
    always_comb begin
        next_state = state;
        case (state)
            ST_INIT: if (&cnt) next_state = ST_RUN;
            ST_RUN:  next_state = ST_RUN;
            default: next_state = ST_INIT;
        endcase
    end

    always_comb begin
        run_c     = 1'b0;
        pa_en_c   = 1'b0;
        pa_we_c   = '0;
        pa_addr_c = addr_a;
        pa_din_c  = din_a;
        case (state)
            ST_INIT: begin
                pa_en_c   = 1'b1;
                pa_we_c   = '1;
                pa_addr_c = cnt;
                pa_din_c  = '0;
            end
            ST_RUN: begin
                run_c   = 1'b1;
                pa_en_c = en_a;
                pa_we_c = we_a;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (state == ST_INIT) begin
            cnt <= cnt + ADDR_WIDTH'(1);
        end
    end

    // Rises on the same edge that moves the FSM into RUN.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            init_done <= 1'b0;
        end else begin
            init_done <= (next_state == ST_RUN);
        end
    end

endmodule

// File: rtl/tdp_ram_be.sv
// True-dual-port RAM with byte enables, read-valid strobes, deterministic
// collision merge and a post-reset clear sweep.
// Define TDP_RAM_OUT_REG_EN to add an output register stage (latency 2).
module tdp_ram_be
    import tdp_ram_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 6,
    parameter int unsigned BYTE_W     = 8,
    parameter int unsigned READ_MODE  = 0,
    parameter int unsigned COLL_PRIO  = 0,
    localparam int unsigned NB        = DATA_WIDTH / BYTE_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic                  init_done,
    input  logic                  en_a,
    input  logic [NB-1:0]         we_a,
    input  logic [ADDR_WIDTH-1:0] addr_a,
    input  logic [DATA_WIDTH-1:0] din_a,
    output logic [DATA_WIDTH-1:0] dout_a,
    output logic                  rvalid_a,
    input  logic                  en_b,
    input  logic [NB-1:0]         we_b,
    input  logic [ADDR_WIDTH-1:0] addr_b,
    input  logic [DATA_WIDTH-1:0] din_b,
    output logic [DATA_WIDTH-1:0] dout_b,
    output logic                  rvalid_b,
    output logic                  collision,
    output logic [ADDR_WIDTH-1:0] coll_addr
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

    logic                  run_c;
    logic                  pa_en_c;
    logic [NB-1:0]         pa_we_c;
    logic [ADDR_WIDTH-1:0] pa_addr_c;
    logic [DATA_WIDTH-1:0] pa_din_c;

    tdp_ram_init_ctrl #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .NB         (NB)
    ) u_init_ctrl (
        .clk       (clk),
        .rst_n     (rst_n),
        .en_a      (en_a),
        .we_a      (we_a),
        .addr_a    (addr_a),
        .din_a     (din_a),
        .init_done (init_done),
        .run_c     (run_c),
        .pa_en_c   (pa_en_c),
        .pa_we_c   (pa_we_c),
        .pa_addr_c (pa_addr_c),
        .pa_din_c  (pa_din_c)
    );

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  acc_a_c;
    logic                  acc_b_c;
    logic                  wr_a_c;
    logic                  wr_b_c;
    logic                  same_c;
    logic                  coll_c;
    logic [DATA_WIDTH-1:0] old_a_c;
    logic [DATA_WIDTH-1:0] old_b_c;
    logic [DATA_WIDTH-1:0] mask_a_c;
    logic [DATA_WIDTH-1:0] mask_b_c;
    logic [DATA_WIDTH-1:0] win_a_c;
    logic [DATA_WIDTH-1:0] win_b_c;
    logic [DATA_WIDTH-1:0] new_a_c;
    logic [DATA_WIDTH-1:0] new_b_c;
    logic [DATA_WIDTH-1:0] rd_a_c;
    logic [DATA_WIDTH-1:0] rd_b_c;

    // User accesses only count in RUN; the sweep uses port A without a strobe.
    always_comb begin
        acc_a_c = run_c & en_a;
        acc_b_c = run_c & en_b;
        wr_a_c  = pa_en_c & (|pa_we_c);
        wr_b_c  = acc_b_c & (|we_b);
        same_c  = (pa_addr_c == addr_b);
        coll_c  = acc_a_c & acc_b_c & (addr_a == addr_b) & ((|we_a) | (|we_b));
    end

    // Merge both ports' lanes; on shared lanes of a shared address the loser is masked off.
    always_comb begin
        old_a_c  = mem[pa_addr_c];
        old_b_c  = mem[addr_b];
        mask_a_c = wr_a_c ? DATA_WIDTH'(lane_mask(MAX_NB'(pa_we_c), BYTE_W, NB)) : '0;
        mask_b_c = wr_b_c ? DATA_WIDTH'(lane_mask(MAX_NB'(we_b), BYTE_W, NB)) : '0;
        win_a_c  = mask_a_c;
        win_b_c  = mask_b_c;
        if (same_c) begin
            if (COLL_PRIO == PRIO_A) begin
                win_b_c = mask_b_c & ~mask_a_c;
            end else begin
                win_a_c = mask_a_c & ~mask_b_c;
            end
        end
        if (same_c) begin
            new_a_c = (old_a_c & ~(mask_a_c | mask_b_c)) | (pa_din_c & win_a_c) | (din_b & win_b_c);
            new_b_c = new_a_c;
        end else begin
            new_a_c = (old_a_c & ~mask_a_c) | (pa_din_c & mask_a_c);
            new_b_c = (old_b_c & ~mask_b_c) | (din_b & mask_b_c);
        end
        rd_a_c = ((READ_MODE == RM_WRITE_FIRST) && wr_a_c) ? new_a_c : old_a_c;
        rd_b_c = ((READ_MODE == RM_WRITE_FIRST) && wr_b_c) ? new_b_c : old_b_c;
    end

    // Array contents are cleared by the sweep rather than by reset.
    always_ff @(posedge clk) begin
        if (wr_a_c) begin
            mem[pa_addr_c] <= new_a_c;
        end
        if (wr_b_c) begin
            mem[addr_b] <= new_b_c;
        end
    end

    logic [DATA_WIDTH-1:0] dout_a_q;
    logic [DATA_WIDTH-1:0] dout_b_q;
    logic                  rvalid_a_q;
    logic                  rvalid_b_q;
    logic                  coll_q;
    logic [ADDR_WIDTH-1:0] coll_addr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout_a_q    <= '0;
            dout_b_q    <= '0;
            rvalid_a_q  <= 1'b0;
            rvalid_b_q  <= 1'b0;
            coll_q      <= 1'b0;
            coll_addr_q <= '0;
        end else begin
            rvalid_a_q <= acc_a_c;
            rvalid_b_q <= acc_b_c;
            coll_q     <= coll_c;
            if (acc_a_c) dout_a_q <= rd_a_c;
            if (acc_b_c) dout_b_q <= rd_b_c;
            if (coll_c)  coll_addr_q <= addr_a;
        end
    end

`ifdef TDP_RAM_OUT_REG_EN
    // Retiming stage; the first stage already holds data between accesses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout_a    <= '0;
            dout_b    <= '0;
            rvalid_a  <= 1'b0;
            rvalid_b  <= 1'b0;
            collision <= 1'b0;
            coll_addr <= '0;
        end else begin
            dout_a    <= dout_a_q;
            dout_b    <= dout_b_q;
            rvalid_a  <= rvalid_a_q;
            rvalid_b  <= rvalid_b_q;
            collision <= coll_q;
            coll_addr <= coll_addr_q;
        end
    end
`else
    assign dout_a    = dout_a_q;
    assign dout_b    = dout_b_q;
    assign rvalid_a  = rvalid_a_q;
    assign rvalid_b  = rvalid_b_q;
    assign collision = coll_q;
    assign coll_addr = coll_addr_q;
`endif

endmodule

// File: tb/tb_tdp_ram_be.sv
// Bench for tdp_ram_be: two instances (read-first/port-A priority and
// write-first/port-B priority) driven in lockstep and compared to a word-level model.
module tb_tdp_ram_be;

    localparam int unsigned DEPTH = 64;
`ifdef TDP_RAM_OUT_REG_EN
    localparam int unsigned LAT = 2;
`else
    localparam int unsigned LAT = 1;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en_a, en_b;
    logic [3:0]  we_a, we_b;
    logic [5:0]  addr_a, addr_b;
    logic [31:0] din_a, din_b;

    logic [31:0] dout_a0, dout_b0, dout_a1, dout_b1;
    logic        rvalid_a0, rvalid_b0, rvalid_a1, rvalid_b1;
    logic        collision0, collision1, init_done0, init_done1;
    logic [5:0]  coll_addr0, coll_addr1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    tdp_ram_be #(.DATA_WIDTH(32), .ADDR_WIDTH(6), .BYTE_W(8), .READ_MODE(0), .COLL_PRIO(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .init_done(init_done0),
        .en_a(en_a), .we_a(we_a), .addr_a(addr_a), .din_a(din_a), .dout_a(dout_a0), .rvalid_a(rvalid_a0),
        .en_b(en_b), .we_b(we_b), .addr_b(addr_b), .din_b(din_b), .dout_b(dout_b0), .rvalid_b(rvalid_b0),
        .collision(collision0), .coll_addr(coll_addr0));

    tdp_ram_be #(.DATA_WIDTH(32), .ADDR_WIDTH(6), .BYTE_W(8), .READ_MODE(1), .COLL_PRIO(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .init_done(init_done1),
        .en_a(en_a), .we_a(we_a), .addr_a(addr_a), .din_a(din_a), .dout_a(dout_a1), .rvalid_a(rvalid_a1),
        .en_b(en_b), .we_b(we_b), .addr_b(addr_b), .din_b(din_b), .dout_b(dout_b1), .rvalid_b(rvalid_b1),
        .collision(collision1), .coll_addr(coll_addr1));

    typedef struct packed {
        logic [31:0] da;
        logic [31:0] db;
        logic        ra;
        logic        rb;
        logic        co;
        logic [5:0]  ca;
    } out_t;

    logic [31:0] mm [2][DEPTH];
    out_t        cur [2];
    out_t        vis [2];

    function automatic logic [31:0] put(input logic [31:0] word, input logic [31:0] din, input logic [3:0] we);
        logic [31:0] r;
        r = word;
        for (int i = 0; i < 4; i++) begin
            if (we[i]) r[i*8 +: 8] = din[i*8 +: 8];
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Word-level model: apply the losing write first so the winner overwrites shared lanes.
    task automatic model(input bit k, input bit rm, input bit cp);
        logic [31:0] oa, ob;
        logic        wa, wb;
        out_t        prev;
        oa = mm[k][addr_a];
        ob = mm[k][addr_b];
        wa = en_a && (we_a != 4'h0);
        wb = en_b && (we_b != 4'h0);
        if (cp) begin
            if (wa) mm[k][addr_a] = put(mm[k][addr_a], din_a, we_a);
            if (wb) mm[k][addr_b] = put(mm[k][addr_b], din_b, we_b);
        end else begin
            if (wb) mm[k][addr_b] = put(mm[k][addr_b], din_b, we_b);
            if (wa) mm[k][addr_a] = put(mm[k][addr_a], din_a, we_a);
        end
        prev = cur[k];
        cur[k].ra = en_a;
        cur[k].rb = en_b;
        if (en_a) cur[k].da = (rm && wa) ? mm[k][addr_a] : oa;
        if (en_b) cur[k].db = (rm && wb) ? mm[k][addr_b] : ob;
        cur[k].co = en_a && en_b && (addr_a == addr_b) && (wa || wb);
        if (cur[k].co) cur[k].ca = addr_a;
`ifdef TDP_RAM_OUT_REG_EN
        vis[k] = prev;
`else
        vis[k] = cur[k];
`endif
    endtask

    task automatic check_outs();
        chk("dout_a0",   dout_a0,             vis[0].da);
        chk("rvalid_a0", 32'(rvalid_a0),      32'(vis[0].ra));
        chk("dout_b0",   dout_b0,             vis[0].db);
        chk("rvalid_b0", 32'(rvalid_b0),      32'(vis[0].rb));
        chk("coll0",     32'(collision0),     32'(vis[0].co));
        chk("caddr0",    32'(coll_addr0),     32'(vis[0].ca));
        chk("dout_a1",   dout_a1,             vis[1].da);
        chk("rvalid_a1", 32'(rvalid_a1),      32'(vis[1].ra));
        chk("dout_b1",   dout_b1,             vis[1].db);
        chk("rvalid_b1", 32'(rvalid_b1),      32'(vis[1].rb));
        chk("coll1",     32'(collision1),     32'(vis[1].co));
        chk("caddr1",    32'(coll_addr1),     32'(vis[1].ca));
    endtask

    task automatic step();
        model(1'b0, 1'b0, 1'b0);
        model(1'b1, 1'b1, 1'b1);
        @(posedge clk);
        #1;
        check_outs();
    endtask

    task automatic idle();
        en_a = 1'b0; we_a = 4'h0; addr_a = 6'd0; din_a = 32'h0;
        en_b = 1'b0; we_b = 4'h0; addr_b = 6'd0; din_b = 32'h0;
    endtask

    task automatic set_a(input logic e, input logic [3:0] we, input logic [5:0] ad, input logic [31:0] d);
        en_a = e; we_a = we; addr_a = ad; din_a = d;
    endtask

    task automatic set_b(input logic e, input logic [3:0] we, input logic [5:0] ad, input logic [31:0] d);
        en_b = e; we_b = we; addr_b = ad; din_b = d;
    endtask

    task automatic reset_model();
        for (int a = 0; a < DEPTH; a++) begin
            mm[0][6'(a)] = 32'h0;
            mm[1][6'(a)] = 32'h0;
        end
        cur[0] = '0; cur[1] = '0;
        vis[0] = '0; vis[1] = '0;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_init_done"}, 32'({init_done0, init_done1}), 32'd0);
        chk({tag, "_dout0"},     dout_a0 | dout_b0, 32'h0);
        chk({tag, "_dout1"},     dout_a1 | dout_b1, 32'h0);
        chk({tag, "_strobes"},   32'({rvalid_a0, rvalid_b0, collision0, rvalid_a1, rvalid_b1, collision1}), 32'd0);
        chk({tag, "_caddr"},     32'({coll_addr0, coll_addr1}), 32'd0);
    endtask

    // Count edges until init_done while hammering both ports; nothing may leak out.
    task automatic do_init();
        int n;
        n = 0;
        while (init_done0 !== 1'b1 && n < 200) begin
            set_a(1'($urandom_range(0, 1)), 4'($urandom), 6'($urandom), $urandom);
            set_b(1'($urandom_range(0, 1)), 4'($urandom), 6'($urandom), $urandom);
            @(posedge clk);
            #1;
            n++;
            chk("init_quiet", 32'({rvalid_a0, rvalid_b0, collision0, rvalid_a1, rvalid_b1, collision1}), 32'd0);
        end
        chk("init_cycles", 32'(n), 32'(DEPTH));
        chk("init_done1", 32'(init_done1), 32'd1);
        idle();
        reset_model();
    endtask

    task automatic flush();
        idle();
        step();
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        idle();
        reset_model();
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        rst_n = 1'b1;
        do_init();

        for (int a = 0; a < DEPTH; a++) begin
            set_a(1'b1, 4'h0, 6'(a), 32'h0);
            set_b(1'b1, 4'h0, 6'(DEPTH - 1 - a), 32'h0);
            step();
        end
        flush();

        set_a(1'b1, 4'hF, 6'd5, 32'hDEADBEEF); step();
        set_a(1'b1, 4'h1, 6'd5, 32'h000000AA); step();
        idle(); set_b(1'b1, 4'h0, 6'd5, 32'h0); step();
        flush();
        chk("be_merge0", dout_b0, 32'hDEADBEAA);
        chk("be_merge1", dout_b1, 32'hDEADBEAA);

        set_a(1'b1, 4'hF, 6'd3, 32'h11111111); step();
        idle(); step();
        set_a(1'b1, 4'hF, 6'd3, 32'h22222222); step();
        flush();
        chk("read_first", dout_a0, 32'h11111111);
        chk("write_first", dout_a1, 32'h22222222);

        set_a(1'b1, 4'hF, 6'd9, 32'hAAAAAAAA);
        set_b(1'b1, 4'h3, 6'd9, 32'hBBBBBBBB);
        step();
        flush();
        chk("ww_caddr0", 32'(coll_addr0), 32'd9);
        chk("ww_caddr1", 32'(coll_addr1), 32'd9);
        set_a(1'b1, 4'h0, 6'd9, 32'h0); step();
        flush();
        chk("ww_prio_a", dout_a0, 32'hAAAAAAAA);
        chk("ww_prio_b", dout_a1, 32'hAAAABBBB);

        set_a(1'b1, 4'hF, 6'd7, 32'hCAFEF00D);
        set_b(1'b1, 4'h0, 6'd7, 32'h0);
        step();
        flush();
        chk("xport_old0", dout_b0, 32'h0);
        chk("xport_old1", dout_b1, 32'h0);
        chk("xport_caddr", 32'(coll_addr0), 32'd7);
        set_a(1'b1, 4'h0, 6'd7, 32'h0);
        set_b(1'b1, 4'h0, 6'd7, 32'h0);
        step();
        flush();

        for (int i = 0; i < 400; i++) begin
            set_a(1'($urandom_range(0, 3) != 0), ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'h0,
                  6'($urandom_range(0, 7)), $urandom);
            set_b(1'($urandom_range(0, 3) != 0), ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'h0,
                  6'($urandom_range(0, 7)), $urandom);
            step();
        end
        flush();

        set_a(1'b1, 4'hF, 6'd1, 32'h12345678); step();
        set_a(1'b1, 4'h0, 6'd1, 32'h0);
        set_b(1'b1, 4'h0, 6'd1, 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_zero("midrst");
        idle();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        do_init();
        set_a(1'b1, 4'h0, 6'd1, 32'h0);
        set_b(1'b1, 4'h0, 6'd1, 32'h0);
        step();
        flush();
        chk("cleared_a0", dout_a0, 32'h0);
        chk("cleared_b1", dout_b1, 32'h0);

        // Raw latency measurement; the model is not advanced past this point.
        set_a(1'b1, 4'h0, 6'd2, 32'h0);
        @(posedge clk);
        #1;
        idle();
        n = 1;
        while (rvalid_a0 !== 1'b1 && n < 10) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("read_latency", 32'(n), 32'(LAT));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
